// File: rtl/cgra_job_scheduler.sv
// cgra_job_scheduler: queues kernel job descriptors and, one job at a time,
// writes two config words into the CGRA control BRAM, runs the
// Computation_Start/Computation_Done four-phase handshake (optional timeout)
// and returns a completion record.
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   Job_Valid/Ready/Id/Word0/1    descriptor push interface
//   Timeout_Limit                 max Done wait in cycles (0 = no timeout)
//   Ctl_En/Wen/Addr/Data          control-BRAM write port
//   Computation_Start/Done        kernel start/done levels
//   Cpl_Valid/Ready/Id/Timeout    completion record interface
//   Busy                          scheduler active or queue non-empty
// Optional: define CGRA_SCHED_PERF_EN to add Perf_Last_Cycles/Perf_Job_Count.
module cgra_job_scheduler #(
    parameter int unsigned SYS_DWIDTH = 32,
    parameter int unsigned BYTE_LEN   = 4,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned IDW        = 8,
    parameter int unsigned TOW        = 20
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Job_Valid,
    output logic                  Job_Ready,
    input  logic [IDW-1:0]        Job_Id,
    input  logic [SYS_DWIDTH-1:0] Job_Word0,
    input  logic [SYS_DWIDTH-1:0] Job_Word1,
    input  logic [TOW-1:0]        Timeout_Limit,
    output logic                  Ctl_En,
    output logic [BYTE_LEN-1:0]   Ctl_Wen,
    output logic [SYS_DWIDTH-1:0] Ctl_Addr,
    output logic [SYS_DWIDTH-1:0] Ctl_Data,
    output logic                  Computation_Start,
    input  logic                  Computation_Done,
    output logic                  Cpl_Valid,
    input  logic                  Cpl_Ready,
    output logic [IDW-1:0]        Cpl_Id,
    output logic                  Cpl_Timeout,
    output logic                  Busy
`ifdef CGRA_SCHED_PERF_EN
    ,
    output logic [31:0]           Perf_Last_Cycles,
    output logic [31:0]           Perf_Job_Count
`endif
);

    localparam int unsigned AW = $clog2(QDEPTH);

    typedef enum logic [2:0] {IDLE, CFG0, CFG1, RUN, CLR, CPL} state_t;

    state_t state_q, state_d;

    // Job queue storage and pointers (one extra wrap bit)
    logic [IDW-1:0]        q_id    [QDEPTH];
    logic [SYS_DWIDTH-1:0] q_w0    [QDEPTH];
    logic [SYS_DWIDTH-1:0] q_w1    [QDEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  empty, full_d, push, pop;

    logic [IDW-1:0]        hold_id_q;
    logic [SYS_DWIDTH-1:0] hold_w0_q, hold_w1_q;
    logic [TOW-1:0]        tcnt_q, tcnt_d;
    logic                  to_flag_q, to_flag_d;

    logic                  job_ready_q;
    logic                  ctl_en_q, ctl_en_d;
    logic [BYTE_LEN-1:0]   ctl_wen_q, ctl_wen_d;
    logic [SYS_DWIDTH-1:0] ctl_addr_q, ctl_addr_d, ctl_data_q, ctl_data_d;
    logic                  start_q, start_d;
    logic                  cpl_valid_q, cpl_valid_d;
    logic [IDW-1:0]        cpl_id_q, cpl_id_d;
    logic                  cpl_to_q, cpl_to_d;
    logic                  busy_q, busy_d;

    // Job_Ready reflects the current !full, so no bypass when full
    assign push     = Job_Valid && job_ready_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign pop      = (state_q == IDLE) && !empty && !Computation_Done;
    assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    // Queue storage write (no reset needed on payload)
    always_ff @(posedge Clk) begin
        if (push) begin
            q_id[wr_ptr_q[AW-1:0]] <= Job_Id;
            q_w0[wr_ptr_q[AW-1:0]] <= Job_Word0;
            q_w1[wr_ptr_q[AW-1:0]] <= Job_Word1;
        end
    end

    // State register and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hold_id_q <= '0;
            hold_w0_q <= '0;
            hold_w1_q <= '0;
            tcnt_q    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tcnt_q    <= tcnt_d;
            to_flag_q <= to_flag_d;
            if (pop) begin
                hold_id_q <= q_id[rd_ptr_q[AW-1:0]];
                hold_w0_q <= q_w0[rd_ptr_q[AW-1:0]];
                hold_w1_q <= q_w1[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Next-state logic; Done takes priority over a simultaneous timeout hit
    always_comb begin
        state_d   = state_q;
        tcnt_d    = '0;
        to_flag_d = to_flag_q;
        unique case (state_q)
            IDLE: if (!empty && !Computation_Done) state_d = CFG0;
            CFG0: state_d = CFG1;
            CFG1: state_d = RUN;
            RUN: begin
                tcnt_d = tcnt_q + TOW'(1);
                if (Computation_Done) begin
                    state_d   = CLR;
                    to_flag_d = 1'b0;
                end else if ((Timeout_Limit != '0) &&
                             (tcnt_q == Timeout_Limit - TOW'(1))) begin
                    state_d   = CLR;
                    to_flag_d = 1'b1;
                end
            end
            CLR: if (!Computation_Done) state_d = CPL;
            CPL: if (cpl_valid_q && Cpl_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from current state; registered below
    always_comb begin
        ctl_en_d    = 1'b0;
        ctl_wen_d   = '0;
        ctl_addr_d  = '0;
        ctl_data_d  = '0;
        start_d     = 1'b0;
        cpl_valid_d = 1'b0;
        cpl_id_d    = cpl_id_q;
        cpl_to_d    = cpl_to_q;
        busy_d      = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
        unique case (state_q)
            CFG0: begin
                ctl_en_d   = 1'b1;
                ctl_wen_d  = {BYTE_LEN{1'b1}};
                ctl_addr_d = SYS_DWIDTH'(0);
                ctl_data_d = hold_w0_q;
            end
            CFG1: begin
                ctl_en_d   = 1'b1;
                ctl_wen_d  = {BYTE_LEN{1'b1}};
                ctl_addr_d = SYS_DWIDTH'(4);
                ctl_data_d = hold_w1_q;
            end
            RUN: start_d = 1'b1;
            CPL: begin
                // Drop valid right after the accepting edge
                cpl_valid_d = !(cpl_valid_q && Cpl_Ready);
                cpl_id_d    = hold_id_q;
                cpl_to_d    = to_flag_q;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            job_ready_q <= 1'b1;
            ctl_en_q    <= 1'b0;
            ctl_wen_q   <= '0;
            ctl_addr_q  <= '0;
            ctl_data_q  <= '0;
            start_q     <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_id_q    <= '0;
            cpl_to_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            job_ready_q <= !full_d;
            ctl_en_q    <= ctl_en_d;
            ctl_wen_q   <= ctl_wen_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_data_q  <= ctl_data_d;
            start_q     <= start_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_id_q    <= cpl_id_d;
            cpl_to_q    <= cpl_to_d;
            busy_q      <= busy_d;
        end
    end

    assign Job_Ready         = job_ready_q;
    assign Ctl_En            = ctl_en_q;
    assign Ctl_Wen           = ctl_wen_q;
    assign Ctl_Addr          = ctl_addr_q;
    assign Ctl_Data          = ctl_data_q;
    assign Computation_Start = start_q;
    assign Cpl_Valid         = cpl_valid_q;
    assign Cpl_Id            = cpl_id_q;
    assign Cpl_Timeout       = cpl_to_q;
    assign Busy              = busy_q;

`ifdef CGRA_SCHED_PERF_EN
    // RUN-cycle count equals the number of cycles Start is high
    logic [31:0] perf_run_q, perf_last_q, perf_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            perf_run_q  <= '0;
            perf_last_q <= '0;
            perf_cnt_q  <= '0;
        end else begin
            if (state_q == RUN)       perf_run_q <= perf_run_q + 32'(1);
            else if (state_q == IDLE) perf_run_q <= '0;
            if ((state_q == CLR) && (state_d == CPL)) perf_last_q <= perf_run_q;
            if (cpl_valid_q && Cpl_Ready) perf_cnt_q <= perf_cnt_q + 32'(1);
        end
    end

    assign Perf_Last_Cycles = perf_last_q;
    assign Perf_Job_Count   = perf_cnt_q;
`endif

endmodule
